// File: rtl/apu_master_rob.sv
// Core-side APU initiator with a reorder buffer: reserves a result slot per issued
// request, tags it {CORE_ID, slot}, and retires out-of-order results in issue order.
module apu_master_rob #(
    parameter int ID_WIDTH        = 9,
    parameter int NB_ARGS         = 2,
    parameter int OPCODE_WIDTH    = 6,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_IN_WIDTH  = 15,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int NB_SLOTS        = 4,
    parameter int CORE_ID         = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            core_req_i,
    output logic                            core_gnt_o,
    input  logic [NB_ARGS*DATA_WIDTH-1:0]   core_operands_i,
    input  logic [OPCODE_WIDTH-1:0]         core_op_i,
    input  logic [FLAGS_IN_WIDTH-1:0]       core_flags_i,
    output logic                            core_rvalid_o,
    input  logic                            core_rready_i,
    output logic [DATA_WIDTH-1:0]           core_rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0]      core_rflags_o,
    output logic                            apu_req_o,
    input  logic                            apu_gnt_i,
    output logic [ID_WIDTH-1:0]             apu_ID_o,
    output logic [NB_ARGS*DATA_WIDTH-1:0]   apu_operands_o,
    output logic [OPCODE_WIDTH-1:0]         apu_op_o,
    output logic [FLAGS_IN_WIDTH-1:0]       apu_flags_o,
    output logic                            apu_rready_o,
    input  logic                            apu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]           apu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0]      apu_rflags_i,
    input  logic [ID_WIDTH-1:0]             apu_rID_i,
    output logic                            err_o
);

    localparam int SLOT_W = $clog2(NB_SLOTS);
    localparam int CID_W  = ID_WIDTH - SLOT_W;
    localparam logic [CID_W-1:0]  CORE_ID_L = CID_W'(CORE_ID);
    localparam logic [SLOT_W:0]   NB_SLOTS_L = (SLOT_W+1)'(NB_SLOTS);

    logic [SLOT_W-1:0]          alloc_ptr_q, alloc_ptr_d;
    logic [SLOT_W-1:0]          retire_ptr_q, retire_ptr_d;
    logic [SLOT_W:0]            count_q, count_d;
    logic [NB_SLOTS-1:0]        pending_q, pending_d;
    logic [NB_SLOTS-1:0]        done_q, done_d;
    logic [DATA_WIDTH-1:0]      rdata_q [NB_SLOTS];
    logic [DATA_WIDTH-1:0]      rdata_d [NB_SLOTS];
    logic [FLAGS_OUT_WIDTH-1:0] rflags_q [NB_SLOTS];
    logic [FLAGS_OUT_WIDTH-1:0] rflags_d [NB_SLOTS];
    logic                       err_q, err_d;

    logic              full;
    logic              issue;
    logic              retire;
    logic              rsp_ok;
    logic [SLOT_W-1:0] rsp_slot;
    logic [CID_W-1:0]  rsp_core;

    // Handshake: a request issues in the cycle where apu_req_o and apu_gnt_i are both
    // high; a result retires in the cycle where core_rvalid_o and core_rready_i are both high.
    assign full       = (count_q == NB_SLOTS_L);
    assign apu_req_o  = rst_n & core_req_i & ~full;
    assign core_gnt_o = apu_gnt_i & apu_req_o;
    assign issue      = core_gnt_o;

    assign apu_ID_o       = {CORE_ID_L, alloc_ptr_q};
    assign apu_operands_o = core_operands_i;
    assign apu_op_o       = core_op_i;
    assign apu_flags_o    = core_flags_i;
    assign apu_rready_o   = 1'b1;

    assign rsp_slot = apu_rID_i[SLOT_W-1:0];
    assign rsp_core = apu_rID_i[ID_WIDTH-1:SLOT_W];
    assign rsp_ok   = apu_rvalid_i & (rsp_core == CORE_ID_L) & pending_q[rsp_slot];

    assign core_rvalid_o = done_q[retire_ptr_q];
    assign core_rdata_o  = rdata_q[retire_ptr_q];
    assign core_rflags_o = rflags_q[retire_ptr_q];
    assign retire        = core_rvalid_o & core_rready_i;
    assign err_o         = err_q;

    // Issue, response and retire always touch distinct slots, so their updates never collide.
    always_comb begin
        alloc_ptr_d  = alloc_ptr_q;
        retire_ptr_d = retire_ptr_q;
        count_d      = count_q;
        pending_d    = pending_q;
        done_d       = done_q;
        rdata_d      = rdata_q;
        rflags_d     = rflags_q;
        err_d        = err_q;

        if (issue) begin
            pending_d[alloc_ptr_q] = 1'b1;
            alloc_ptr_d            = alloc_ptr_q + 1'b1;
        end

        if (rsp_ok) begin
            pending_d[rsp_slot] = 1'b0;
            done_d[rsp_slot]    = 1'b1;
            rdata_d[rsp_slot]   = apu_rdata_i;
            rflags_d[rsp_slot]  = apu_rflags_i;
        end else if (apu_rvalid_i) begin
            err_d = 1'b1;
        end

        if (retire) begin
            done_d[retire_ptr_q] = 1'b0;
            retire_ptr_d         = retire_ptr_q + 1'b1;
        end

        case ({issue, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr_q  <= '0;
            retire_ptr_q <= '0;
            count_q      <= '0;
            pending_q    <= '0;
            done_q       <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < NB_SLOTS; i++) begin
                rdata_q[i]  <= '0;
                rflags_q[i] <= '0;
            end
        end else begin
            alloc_ptr_q  <= alloc_ptr_d;
            retire_ptr_q <= retire_ptr_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            rflags_q     <= rflags_d;
        end
    end

endmodule
